scalar_divide_mat: RTL and testbench

Sequential matrix-by-scalar divider, the inverse of the team's combinational scalar matrix multiplier. Computes mat_out[i][j] = mat[i][j] / scale, unsigned, on an SIZE_A x SIZE_B matrix. Used in the fetal ECG pipeline to normalise whitening/ICA matrices after scaling. One shared restoring-division datapath, elements processed row-major, start/done handshake.

---
 rtl/scalar_divide_mat_if.sv | 43 ++++
 rtl/scalar_divide_mat.sv | 213 +++++++++++++++++++++
 tb/tb_scalar_divide_mat.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/scalar_divide_mat_if.sv
// scalar_divide_mat_if
//
// Groups the matrix divider's request and result signals.
//
// Handshake: the requester raises start together with stable scale/mat.
// The divider samples start only while idle. Operands are captured on the
// accepting edge, and the requester may change them freely afterwards.
// busy is high from the cycle after acceptance up to and including the done
// cycle. done is a one-cycle pulse, and mat_out/div_by_zero are valid in that
// cycle. A start seen while busy, including the done cycle, is dropped and not
// queued.
//
// Signals:
//   start        requester -> divider   request pulse/level
//   scale        requester -> divider   divisor, N_BITS unsigned
//   mat          requester -> divider   dividend matrix [SIZE_A][SIZE_B]
//   mat_out      divider -> requester   quotient matrix, registered
//   busy         divider -> requester   operation in progress
//   done         divider -> requester   one-cycle completion pulse
//   div_by_zero  divider -> requester   last accepted scale was zero
interface scalar_divide_mat_if #(
  parameter int SIZE_A = 8,
  parameter int SIZE_B = 8,
  parameter int N_BITS = 22
) ();
  logic              start;
  logic [N_BITS-1:0] scale;
  logic [N_BITS-1:0] mat     [SIZE_A][SIZE_B];
  logic [N_BITS-1:0] mat_out [SIZE_A][SIZE_B];
  logic              busy;
  logic              done;
  logic              div_by_zero;

  modport master (
    output start, scale, mat,
    input  mat_out, busy, done, div_by_zero
  );

  modport slave (
    input  start, scale, mat,
    output mat_out, busy, done, div_by_zero
  );
endinterface

// File: rtl/scalar_divide_mat.sv
// scalar_divide_mat
//
// Sequential unsigned matrix-by-scalar divider:
//   mat_out[i][j] = mat[i][j] / scale
// The design uses one shared restoring-division datapath. It retires one
// quotient bit per cycle, MSB first, and walks the elements in row-major order.
//
// Optional build macro:
//   SCALAR_DIV_ROUND_EN  defined   -> round to nearest, ties up, saturating
//                        undefined -> truncate toward zero
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   bus        slave modport of scalar_divide_mat_if (start/scale/mat in,
//              mat_out/busy/done/div_by_zero out)
//   state_dbg  out  current FSM state encoding (IDLE=0, DIV=1, FIN=2)
//
// Timing: counting the edge that samples start as edge 1, done is high after
// edge SIZE_A*SIZE_B*N_BITS+1 for a nonzero scale. For a zero scale, done is
// high after edge 1.
module scalar_divide_mat #(
  parameter int SIZE_A = 8,
  parameter int SIZE_B = 8,
  parameter int N_BITS = 22
) (
  input  logic                clk,
  input  logic                rst_n,
  scalar_divide_mat_if.slave  bus,
  output logic [1:0]          state_dbg
);

  localparam int BW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam int RW = (SIZE_A > 1) ? $clog2(SIZE_A) : 1;
  localparam int CW = (SIZE_B > 1) ? $clog2(SIZE_B) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Captured operands
  logic [N_BITS-1:0] scale_q;
  logic [N_BITS-1:0] mat_q     [SIZE_A][SIZE_B];
  logic [N_BITS-1:0] mat_out_q [SIZE_A][SIZE_B];

  // Division state: the remainder has one spare bit, so the shift never
  // overflows. The partial quotient holds N_BITS-1 bits because the final
  // bit is produced combinationally on the last step.
  logic [N_BITS:0]   rem_q;
  logic [N_BITS-2:0] quo_q;
  logic [BW-1:0]     bit_q;
  logic [RW-1:0]     row_q;
  logic [CW-1:0]     col_q;
  logic              busy_q;
  logic              dbz_q;

  // Control decode
  logic accept;
  logic step_en;
  logic last_bit;
  logic last_elem;

  // Datapath intermediates
  logic [N_BITS-1:0] dividend;
  logic [BW-1:0]     bit_pos;
  logic              next_bit;
  logic [N_BITS+1:0] shifted;
  logic [N_BITS+1:0] scale_ext;
  logic              ge;
  logic [N_BITS:0]   rem_step;
  logic [N_BITS-1:0] quo_step;
  logic [N_BITS-1:0] quo_final;
`ifdef SCALAR_DIV_ROUND_EN
  logic              round_up;
`endif

  // ------------------------------------------------------------------
  // Restoring-division step for the element at (row_q, col_q)
  // ------------------------------------------------------------------
  always_comb begin
    dividend  = mat_q[row_q][col_q];
    bit_pos   = BW'(N_BITS - 1) - bit_q;
    next_bit  = dividend[bit_pos];
    shifted   = {rem_q, next_bit};
    scale_ext = {2'b00, scale_q};
    ge        = (shifted >= scale_ext);
    rem_step  = ge ? (N_BITS+1)'(shifted - scale_ext) : (N_BITS+1)'(shifted);
    quo_step  = {quo_q, ge};
`ifdef SCALAR_DIV_ROUND_EN
    // The remainder is already below scale here. Round up when it is at
    // least half of scale. The quotient can only be all ones when scale == 1,
    // and then the remainder is zero, so the saturation guard is just a
    // safety net.
    round_up  = ({rem_step, 1'b0} >= {1'b0, scale_ext});
    quo_final = (round_up && !(&quo_step)) ? quo_step + 1'b1 : quo_step;
`else
    quo_final = quo_step;
`endif
  end

  assign last_bit  = (bit_q == BW'(N_BITS - 1));
  assign last_elem = (row_q == RW'(SIZE_A - 1)) && (col_q == CW'(SIZE_B - 1));

  // ------------------------------------------------------------------
  // FSM next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = (bus.scale == '0) ? FIN : DIV;
        end
      end
      DIV: begin
        step_en = 1'b1;
        if (last_bit && last_elem) state_d = FIN;
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // State, operand capture and datapath registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      scale_q <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      bit_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      busy_q  <= 1'b0;
      dbz_q   <= 1'b0;
      for (int i = 0; i < SIZE_A; i++) begin
        for (int j = 0; j < SIZE_B; j++) begin
          mat_q[i][j]     <= '0;
          mat_out_q[i][j] <= '0;
        end
      end
    end else begin
      state_q <= state_d;

      if (accept) begin
        scale_q <= bus.scale;
        for (int i = 0; i < SIZE_A; i++) begin
          for (int j = 0; j < SIZE_B; j++) begin
            mat_q[i][j] <= bus.mat[i][j];
          end
        end
        rem_q  <= '0;
        quo_q  <= '0;
        bit_q  <= '0;
        row_q  <= '0;
        col_q  <= '0;
        busy_q <= 1'b1;
        dbz_q  <= (bus.scale == '0);
        // A zero divisor saturates every quotient and skips the datapath.
        if (bus.scale == '0) begin
          for (int i = 0; i < SIZE_A; i++) begin
            for (int j = 0; j < SIZE_B; j++) begin
              mat_out_q[i][j] <= '1;
            end
          end
        end
      end else if (step_en) begin
        if (last_bit) begin
          mat_out_q[row_q][col_q] <= quo_final;
          rem_q <= '0;
          quo_q <= '0;
          bit_q <= '0;
          if (col_q == CW'(SIZE_B - 1)) begin
            col_q <= '0;
            row_q <= row_q + 1'b1;
          end else begin
            col_q <= col_q + 1'b1;
          end
        end else begin
          rem_q <= rem_step;
          quo_q <= quo_step[N_BITS-2:0];
          bit_q <= bit_q + 1'b1;
        end
      end

      // busy covers the done cycle and drops on the return to IDLE.
      if (state_q == FIN) busy_q <= 1'b0;
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign bus.mat_out     = mat_out_q;
  assign bus.busy        = busy_q;
  assign bus.done        = (state_q == FIN);
  assign bus.div_by_zero = dbz_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_scalar_divide_mat.sv
// tb_scalar_divide_mat
//
// Directed table-driven bench for a 2x2, 8-bit scalar_divide_mat. Both build
// variants are covered: the expected quotients switch on SCALAR_DIV_ROUND_EN.
module tb_scalar_divide_mat;

  localparam int SA = 2;
  localparam int SB = 2;
  localparam int NB = 8;
  localparam int NV = 6;
  localparam int FULL_LAT = SA * SB * NB + 1;

  logic       clk;
  logic       rst_n;
  logic [1:0] state_dbg;

  scalar_divide_mat_if #(.SIZE_A(SA), .SIZE_B(SB), .N_BITS(NB)) bus ();

  scalar_divide_mat #(.SIZE_A(SA), .SIZE_B(SB), .N_BITS(NB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- vector table ----------------
  typedef struct {
    logic [NB-1:0] scale;
    logic [NB-1:0] m      [4];
    logic [NB-1:0] exp_tr [4];
    logic [NB-1:0] exp_rn [4];
    logic          exp_dbz;
    int            exp_lat;
  } vec_t;

  vec_t vecs [NV];

  int n_checks;
  int n_fail;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_vec(input int idx, input int s,
                         input int m0, input int m1, input int m2, input int m3,
                         input int t0, input int t1, input int t2, input int t3,
                         input int r0, input int r1, input int r2, input int r3,
                         input int dbz, input int lat);
    vecs[idx].scale     = NB'(s);
    vecs[idx].m[0]      = NB'(m0);
    vecs[idx].m[1]      = NB'(m1);
    vecs[idx].m[2]      = NB'(m2);
    vecs[idx].m[3]      = NB'(m3);
    vecs[idx].exp_tr[0] = NB'(t0);
    vecs[idx].exp_tr[1] = NB'(t1);
    vecs[idx].exp_tr[2] = NB'(t2);
    vecs[idx].exp_tr[3] = NB'(t3);
    vecs[idx].exp_rn[0] = NB'(r0);
    vecs[idx].exp_rn[1] = NB'(r1);
    vecs[idx].exp_rn[2] = NB'(r2);
    vecs[idx].exp_rn[3] = NB'(r3);
    vecs[idx].exp_dbz   = dbz[0];
    vecs[idx].exp_lat   = lat;
  endtask

  function automatic int exp_q(input int idx, input int k);
`ifdef SCALAR_DIV_ROUND_EN
    return int'(vecs[idx].exp_rn[k]);
`else
    return int'(vecs[idx].exp_tr[k]);
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_op(input logic [NB-1:0] s, input logic [NB-1:0] m0,
                          input logic [NB-1:0] m1, input logic [NB-1:0] m2,
                          input logic [NB-1:0] m3);
    bus.start     = 1'b1;
    bus.scale     = s;
    bus.mat[0][0] = m0;
    bus.mat[0][1] = m1;
    bus.mat[1][0] = m2;
    bus.mat[1][1] = m3;
  endtask

  task automatic check_results(input int idx, input string tag);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s mat_out[%0d]", tag, k),
            int'(bus.mat_out[k / SB][k % SB]), exp_q(idx, k));
    end
    check({tag, " div_by_zero"}, int'(bus.div_by_zero), int'(vecs[idx].exp_dbz));
  endtask

  // Start an operation. Edge 1 samples start. The task waits, with a bound,
  // for done and checks latency, busy coverage, results and the done pulse.
  task automatic run_vec(input int idx, input string tag);
    int  lat;
    bit  got;
    bit  busy_bad;
    lat = 0; got = 0; busy_bad = 0;
    drive_op(vecs[idx].scale, vecs[idx].m[0], vecs[idx].m[1],
             vecs[idx].m[2], vecs[idx].m[3]);
    while (!got && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        bus.start = 1'b0;
        // Scramble the inputs to prove the operands were captured.
        bus.mat[0][0] = 8'hA5;
        bus.scale     = 8'h11;
      end
      if (bus.done) got = 1;
      else if (!bus.busy) busy_bad = 1;
    end
    check({tag, " done seen"}, int'(got), 1);
    check({tag, " latency"}, lat, vecs[idx].exp_lat);
    check({tag, " busy low early"}, int'(busy_bad), 0);
    check({tag, " busy at done"}, int'(bus.busy), 1);
    check_results(idx, tag);
    @(posedge clk); #1;
    check({tag, " done pulse width"}, int'(bus.done), 0);
    check({tag, " busy after done"}, int'(bus.busy), 0);
    check({tag, " dbz held"}, int'(bus.div_by_zero), int'(vecs[idx].exp_dbz));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int dones;
    int first_lat;
    int zero_bad;

    n_checks = 0;
    n_fail   = 0;

    //         idx scale  mat                 trunc               round          dbz lat
    set_vec(0,   3,   10,  20,  30, 255,   3,   6, 10, 85,    3,   7, 10, 85,  0, FULL_LAT);
    set_vec(1,   2,  255,   1,   0,   3, 127,   0,  0,  1,  128,   1,  0,  2,  0, FULL_LAT);
    set_vec(2,   0,    5,   6,   7,   8, 255, 255,255,255,  255, 255,255,255,  1, 1);
    set_vec(3,   1,    5,   6,   7,   8,   5,   6,  7,  8,    5,   6,  7,  8,  0, FULL_LAT);
    set_vec(4, 255,  254, 255,   0, 128,   0,   1,  0,  0,    1,   1,  0,  1,  0, FULL_LAT);
    set_vec(5,   7,  100,  49,   6, 200,  14,   7,  0, 28,   14,   7,  1, 29,  0, FULL_LAT);

    // Reset
    rst_n = 1'b0;
    drive_op(8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset state", int'(state_dbg), 0);
    check("reset busy", int'(bus.busy), 0);
    check("reset done", int'(bus.done), 0);
    check("reset dbz", int'(bus.div_by_zero), 0);
    for (int k = 0; k < 4; k++)
      check($sformatf("reset mat_out[%0d]", k), int'(bus.mat_out[k / SB][k % SB]), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table vectors. Vector 3 follows the zero-divisor vector and must clear
    // the flag.
    for (int v = 0; v < NV; v++) begin
      run_vec(v, $sformatf("vec%0d", v));
      repeat (2) @(posedge clk);
      #1;
    end

    // A start mid-operation is ignored. A start during the done cycle is
    // ignored as well.
    dones = 0; first_lat = 0;
    drive_op(vecs[0].scale, vecs[0].m[0], vecs[0].m[1], vecs[0].m[2], vecs[0].m[3]);
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (c == 1)  bus.start = 1'b0;
      if (c == 10) drive_op(8'd5, 8'd1, 8'd2, 8'd3, 8'd4);
      if (c == 11) bus.start = 1'b0;
      if (first_lat != 0 && c == first_lat + 1) bus.start = 1'b0;
      if (bus.done) begin
        dones++;
        if (first_lat == 0) begin
          first_lat = c;
          check_results(0, "ignored-start");
          // Start with scale 0 during the done cycle. If this start were
          // taken, it would raise div_by_zero.
          drive_op(8'd0, 8'd9, 8'd9, 8'd9, 8'd9);
        end
      end
    end
    check("ignored-start done count", dones, 1);
    check("ignored-start latency", first_lat, FULL_LAT);
    check("start in done cycle dbz", int'(bus.div_by_zero), 0);
    check("start in done cycle state", int'(state_dbg), 0);
    check_results(0, "ignored-start final");

    // Reset asserted mid-division
    drive_op(vecs[5].scale, vecs[5].m[0], vecs[5].m[1], vecs[5].m[2], vecs[5].m[3]);
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk); #1;
      if (c == 1) bus.start = 1'b0;
    end
    check("mid-div busy before reset", int'(bus.busy), 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid-reset state", int'(state_dbg), 0);
    check("mid-reset busy", int'(bus.busy), 0);
    check("mid-reset done", int'(bus.done), 0);
    zero_bad = 0;
    for (int k = 0; k < 4; k++)
      if (bus.mat_out[k / SB][k % SB] != '0) zero_bad++;
    check("mid-reset mat_out nonzero count", zero_bad, 0);
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    check("no done after mid-reset", dones, 0);
    run_vec(0, "post-reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
